// File: rtl/ccl_frame_sequencer.sv
// ccl_frame_sequencer: frame-level controller for the connected-components
// labeling datapath. Runs one frame as clear -> raster scan -> merge-stack
// drain -> (optional) merge-table flatten, then pulses done.
//
// Build option: define CCL_FLATTEN_EN to compile in the flatten pass
// (FLAT_RD/FLAT_WR). Without it the drain goes straight to DONE and the merge
// table is left with chained entries.
//
// The label word width comes from the WORD_SIZE macro (defaults to 16).

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module ccl_frame_sequencer #(
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int XW      = 10,
  parameter int YW      = 9
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      pixel_valid,
  output logic                      pixel_ready,
  output logic                      label_en,
  output logic                      clr,
  output logic [XW-1:0]             x,
  output logic [YW-1:0]             y,
  input  logic [`WORD_SIZE-1:0]     num_labels,
  input  logic                      stack_empty,
  input  logic [2*`WORD_SIZE-1:0]   stack_top,
  output logic                      stack_pop,
  output logic [`WORD_SIZE-1:0]     tbl_raddr,
  input  logic [`WORD_SIZE-1:0]     tbl_rdata,
  output logic                      tbl_we,
  output logic [`WORD_SIZE-1:0]     tbl_waddr,
  output logic [`WORD_SIZE-1:0]     tbl_wdata,
  output logic                      busy,
  output logic                      done
);

  localparam int WS = `WORD_SIZE;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_SCAN    = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
`ifdef CCL_FLATTEN_EN
  localparam logic [2:0] S_FLAT_RD = 3'd4;
  localparam logic [2:0] S_FLAT_WR = 3'd5;
`endif
  localparam logic [2:0] S_DONE    = 3'd6;

  // Last column / last row of the frame, sized to the counters.
  localparam logic [XW-1:0] X_LAST = XW'(FRAME_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);

  logic [2:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

`ifdef CCL_FLATTEN_EN
  // i walks labels 1..num_labels-1; r holds the parent read in FLAT_RD.
  logic [WS-1:0] i_q, i_d;
  logic [WS-1:0] r_q, r_d;
`else
  // Label count only matters to the flatten pass.
  logic unused_num_labels;
  assign unused_num_labels = ^num_labels;
`endif

  // Next-state and output decode from the current state and live inputs.
  always_comb begin
    // NOTE: every output and next-state value gets a default first so no
    // path through the case statement can infer a latch.
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    pixel_ready = 1'b0;
    label_en    = 1'b0;
    clr         = 1'b0;
    stack_pop   = 1'b0;
    tbl_raddr   = '0;
    tbl_we      = 1'b0;
    tbl_waddr   = '0;
    tbl_wdata   = '0;
    done        = 1'b0;
`ifdef CCL_FLATTEN_EN
    i_d         = i_q;
    r_d         = r_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        clr     = 1'b1;
        x_d     = '0;
        y_d     = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        pixel_ready = 1'b1;
        label_en    = pixel_valid;
        if (pixel_valid) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              state_d = S_DRAIN;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (stack_empty) begin
`ifdef CCL_FLATTEN_EN
          i_d     = WS'(1);
          state_d = S_FLAT_RD;
`else
          state_d = S_DONE;
`endif
        end else begin
          // Retire one {max,min} pair: table[max] <= table[min].
          stack_pop = 1'b1;
          tbl_raddr = stack_top[WS-1:0];
          tbl_we    = 1'b1;
          tbl_waddr = stack_top[2*WS-1:WS];
          tbl_wdata = tbl_rdata;
        end
      end
`ifdef CCL_FLATTEN_EN
      S_FLAT_RD: begin
        if (i_q >= num_labels) begin
          state_d = S_DONE;
        end else begin
          tbl_raddr = i_q;
          r_d       = tbl_rdata;
          state_d   = S_FLAT_WR;
        end
      end
      S_FLAT_WR: begin
        // Parent r < i was already flattened, so table[r] is a root.
        tbl_raddr = r_q;
        tbl_we    = 1'b1;
        tbl_waddr = i_q;
        tbl_wdata = tbl_rdata;
        i_d       = i_q + 1'b1;
        state_d   = S_FLAT_RD;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
`ifdef CCL_FLATTEN_EN
      i_q     <= '0;
      r_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
`ifdef CCL_FLATTEN_EN
      i_q     <= i_d;
      r_q     <= r_d;
`endif
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ccl_frame_sequencer.sv
// Self-checking bench for ccl_frame_sequencer on a 4x2 frame. A behavioural
// merge stack and merge table surround the DUT; expected table contents come
// from a label-level model (pair merges, then root chasing when flatten is
// compiled in).

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module tb_ccl_frame_sequencer;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int XW    = 2;
  localparam int YW    = 1;
  localparam int WS    = `WORD_SIZE;
  localparam int DEPTH = 16;
`ifdef CCL_FLATTEN_EN
  localparam bit FLAT = 1'b1;
`else
  localparam bit FLAT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic            pixel_valid = 1'b0;
  logic            pixel_ready, label_en, clr;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [WS-1:0]   num_labels = WS'(1);
  logic            stack_empty;
  logic [2*WS-1:0] stack_top;
  logic            stack_pop;
  logic [WS-1:0]   tbl_raddr, tbl_rdata, tbl_waddr, tbl_wdata;
  logic            tbl_we, busy, done;

  int tests_run = 0;
  int tests_failed = 0;

  ccl_frame_sequencer #(.FRAME_W(W), .FRAME_H(H), .XW(XW), .YW(YW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .label_en(label_en), .clr(clr), .x(x), .y(y),
    .num_labels(num_labels), .stack_empty(stack_empty), .stack_top(stack_top),
    .stack_pop(stack_pop), .tbl_raddr(tbl_raddr), .tbl_rdata(tbl_rdata),
    .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Environment: merge table (combinational read) and merge stack in pop order.
  logic [WS-1:0]   mem [DEPTH];
  logic [WS-1:0]   load_mem [DEPTH];
  logic [2*WS-1:0] stk [DEPTH];
  logic [2*WS-1:0] load_stk [DEPTH];
  logic            load_req = 1'b0;
  int              load_n = 0;
  int              stk_n = 0;
  int              sp = 0;
  int              wr_cnt = 0;
  int              pop_cnt = 0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= load_mem[k];
        stk[k] <= load_stk[k];
      end
      stk_n   <= load_n;
      sp      <= 0;
      wr_cnt  <= 0;
      pop_cnt <= 0;
    end else begin
      if (tbl_we) begin
        mem[tbl_waddr[3:0]] <= tbl_wdata;
        wr_cnt <= wr_cnt + 1;
      end
      if (stack_pop) begin
        sp      <= sp + 1;
        pop_cnt <= pop_cnt + 1;
      end
    end
  end

  assign stack_empty = (sp >= stk_n);
  assign stack_top   = stk[sp[3:0]];
  assign tbl_rdata   = mem[tbl_raddr[3:0]];

  task automatic load_env();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic set_identity();
    for (int k = 0; k < DEPTH; k++) begin
      load_mem[k] = WS'(k);
      load_stk[k] = '0;
    end
    load_n = 0;
  endtask

  // One full frame from start to done, checked cycle by cycle.
  task automatic run_frame(input int n_stalls, input bit pulse_start);
    logic [WS-1:0] expv [DEPTH];
    logic [WS-1:0] drained [DEPTH];
    logic [WS-1:0] pair_data [DEPTH];
    logic [WS-1:0] mx, mn;
    int n, p, stalls_left, pulses, cyc, r, exp_cyc, exp_wr;
    bit v;

    // Reference model.
    n = int'(num_labels);
    for (int k = 0; k < DEPTH; k++) expv[k] = load_mem[k];
    for (int j = 0; j < load_n; j++) begin
      mx = load_stk[j][2*WS-1:WS];
      mn = load_stk[j][WS-1:0];
      pair_data[j] = expv[mn];
      expv[mx] = expv[mn];
    end
    exp_cyc = 0;
    exp_wr  = load_n;
    if (FLAT) begin
      for (int k = 0; k < DEPTH; k++) drained[k] = expv[k];
      for (int k = 1; k < n; k++) begin
        r = k;
        for (int g = 0; g < 32 && int'(drained[r]) != r; g++) r = int'(drained[r]);
        expv[k] = WS'(r);
      end
      exp_cyc = 2 * (n - 1) + 1;
      exp_wr  = load_n + n - 1;
    end

    load_env();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if ({clr, busy, pixel_ready} !== 3'b110) begin
      tests_failed++;
      $display("FAIL init_clr: {clr,busy,ready}=%b expected 110", {clr, busy, pixel_ready});
    end
    @(posedge clk); #1;

    // Scan with exactly n_stalls hold cycles at random points.
    p = 0; stalls_left = n_stalls; pulses = 0;
    while (p < W * H) begin
      v = !(stalls_left > 0 && ($urandom_range(0, 1) == 0 || p == W * H - 1));
      if (!v) stalls_left--;
      pixel_valid = v;
      start = pulse_start && (p == 3);
      #1;
      tests_run++;
      if ({pixel_ready, label_en, clr} !== {1'b1, v, 1'b0}) begin
        tests_failed++;
        $display("FAIL scan_ctrl p=%0d: {ready,en,clr}=%b expected %b", p,
                 {pixel_ready, label_en, clr}, {1'b1, v, 1'b0});
      end
      tests_run++;
      if ({x, y} !== {XW'(p % W), YW'(p / W)}) begin
        tests_failed++;
        $display("FAIL scan_xy p=%0d: x=%0d y=%0d expected x=%0d y=%0d", p, x, y, p % W, p / W);
      end
      if (label_en === 1'b1) pulses++;
      @(posedge clk); #1;
      if (v) p++;
    end
    pixel_valid = 1'b0;
    start = 1'b0;
    tests_run++;
    if (pulses !== W * H) begin
      tests_failed++;
      $display("FAIL label_pulses: got %0d expected %0d", pulses, W * H);
    end

    // Drain: one pair per cycle in stack order.
    for (int j = 0; j < load_n; j++) begin
      tests_run++;
      if ({stack_pop, tbl_we, pixel_ready} !== 3'b110 ||
          tbl_waddr !== load_stk[j][2*WS-1:WS] || tbl_wdata !== pair_data[j]) begin
        tests_failed++;
        $display("FAIL drain_pair %0d: pop=%b we=%b waddr=%0d wdata=%0d expected pop=1 we=1 waddr=%0d wdata=%0d",
                 j, stack_pop, tbl_we, tbl_waddr, tbl_wdata, load_stk[j][2*WS-1:WS], pair_data[j]);
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if ({stack_pop, tbl_we, done, busy, pixel_ready} !== 5'b00010) begin
      tests_failed++;
      $display("FAIL drain_empty: {pop,we,done,busy,ready}=%b expected 00010",
               {stack_pop, tbl_we, done, busy, pixel_ready});
    end

    // Cycles from the drain-empty cycle to done.
    cyc = 0;
    @(posedge clk); #1;
    while (done !== 1'b1 && cyc < 200) begin
      cyc++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (done !== 1'b1 || cyc !== exp_cyc) begin
      tests_failed++;
      $display("FAIL done_latency: done=%b after %0d cycles expected done=1 after %0d", done, cyc, exp_cyc);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL busy_fall: {busy,done}=%b expected 00", {busy, done});
    end
    tests_run++;
    if (wr_cnt !== exp_wr || pop_cnt !== load_n) begin
      tests_failed++;
      $display("FAIL write_pop_count: writes=%0d pops=%0d expected writes=%0d pops=%0d",
               wr_cnt, pop_cnt, exp_wr, load_n);
    end
    for (int k = 0; k < DEPTH; k++) begin
      tests_run++;
      if (mem[k] !== expv[k]) begin
        tests_failed++;
        $display("FAIL table[%0d]: got %0d expected %0d", k, mem[k], expv[k]);
      end
    end
  endtask

  task automatic test_reset();
    int guard;
    #1;
    tests_run++;
    if ({pixel_ready, label_en, clr, stack_pop, tbl_we, busy, done, x, y,
         tbl_raddr, tbl_waddr, tbl_wdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: outputs not all zero during reset");
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    set_identity();
    num_labels = WS'(1);
    load_env();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    // Advance into the scan until the pixel (2,1) is current.
    pixel_valid = 1'b1;
    guard = 0;
    while (!(x == XW'(2) && y == YW'(1)) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    tests_run++;
    if ({x, y, busy} !== {XW'(2), YW'(1), 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_reach: x=%0d y=%0d busy=%b expected x=2 y=1 busy=1", x, y, busy);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({pixel_ready, label_en, clr, stack_pop, tbl_we, busy, done, x, y,
         tbl_raddr, tbl_waddr, tbl_wdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_async: outputs not all zero after mid-scan reset (x=%0d y=%0d busy=%b)",
               x, y, busy);
    end
    pixel_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({busy, clr, pixel_ready} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_idle: {busy,clr,ready}=%b expected 000", {busy, clr, pixel_ready});
    end
    // Restart must begin from (0,0); checked inside the frame.
    run_frame(0, 1'b0);
  endtask

  task automatic test_scan_stalls();
    set_identity();
    num_labels = WS'(1);
    run_frame(3, 1'b0);
  endtask

  task automatic test_drain();
    set_identity();
    load_stk[0] = {WS'(5), WS'(2)};
    load_stk[1] = {WS'(4), WS'(1)};
    load_n = 2;
    num_labels = WS'(6);
    run_frame(0, 1'b0);
  endtask

  task automatic test_flatten();
    set_identity();
    load_mem[1] = WS'(1);
    load_mem[2] = WS'(1);
    load_mem[3] = WS'(2);
    load_mem[4] = WS'(3);
    num_labels = WS'(5);
    run_frame(1, 1'b0);
  endtask

  task automatic test_no_labels();
    set_identity();
    num_labels = WS'(1);
    run_frame(0, 1'b0);
  endtask

  task automatic test_protocol();
    set_identity();
    num_labels = WS'(3);
    load_stk[0] = {WS'(2), WS'(1)};
    load_n = 1;
    run_frame(2, 1'b1);
  endtask

  task automatic test_random();
    int n, mx, mn;
    for (int it = 0; it < 5; it++) begin
      n = int'($urandom_range(1, 15));
      load_mem[0] = '0;
      for (int k = 1; k < DEPTH; k++) load_mem[k] = WS'($urandom_range(1, k));
      for (int k = 0; k < DEPTH; k++) load_stk[k] = '0;
      load_n = (n >= 3) ? int'($urandom_range(0, 6)) : 0;
      for (int j = 0; j < load_n; j++) begin
        mx = int'($urandom_range(2, n - 1));
        mn = int'($urandom_range(1, mx - 1));
        load_stk[j] = {WS'(mx), WS'(mn)};
      end
      num_labels = WS'(n);
      run_frame(int'($urandom_range(0, 4)), it[0]);
    end
  endtask

  initial begin
    test_reset();
    test_scan_stalls();
    test_drain();
    test_flatten();
    test_no_labels();
    test_protocol();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ccl_frame_sequencer.md
# ccl_frame_sequencer

Frame-level controller for the connected-components labeling datapath. It runs one frame as a fixed sequence of phases:
- clear the labeler and its merge stack;
- raster-scan one frame of pixels, gating the labeler enable;
- drain the merge stack into the merge table;
- optionally flatten the merge table so every label maps directly to its root.

It sits between the pixel source and the labeler, merge stack and merge table, and signals frame completion downstream.

## Interface
Parameters:
- FRAME_W, 640, pixels per line; must be ≥ 1.
- FRAME_H, 480, lines per frame; must be ≥ 1.
- XW, 10, width of the x counter; requires 2^XW ≥ FRAME_W.
- YW, 9, width of the y counter; requires 2^YW ≥ FRAME_H.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- start  in  1  begin a frame; sampled only in IDLE.
- pixel_valid  in  1  upstream pixel strobe.
- pixel_ready  out  1  sequencer accepts pixels.
- label_en  out  1  labeler enable.
- clr  out  1  one-cycle synchronous clear for the labeler and merge stack.
- x  out  XW  column of the current pixel.
- y  out  YW  row of the current pixel.
- num_labels  in  `WORD_SIZE  labeler's next free label; 1 means no labels.
- stack_empty  in  1  merge stack empty.
- stack_top  in  2*`WORD_SIZE  {max_label, min_label} on top of the stack.
- stack_pop  out  1  pop the merge stack.
- tbl_raddr  out  `WORD_SIZE  merge-table read address; the read is combinational.
- tbl_rdata  in  `WORD_SIZE  merge-table read data.
- tbl_we  out  1  merge-table write enable.
- tbl_waddr  out  `WORD_SIZE  merge-table write address.
- tbl_wdata  out  `WORD_SIZE  merge-table write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame completion.

## Operation
States: IDLE, INIT, SCAN, DRAIN, FLAT_RD, FLAT_WR, DONE.

- **IDLE**
  - With start=1, go to INIT.
- **INIT**
  - clr=1 for exactly one cycle.
  - Zero x and y.
  - Go to SCAN.
- **SCAN**
  - pixel_ready=1 and label_en = pixel_valid.
  - On each accepted pixel, x increments. At x=FRAME_W-1, x wraps to 0 and y increments.
  - Accepting pixel (FRAME_W-1, FRAME_H-1) moves to DRAIN.
  - With pixel_valid=0, the sequencer holds: no counter change, label_en=0.
- **DRAIN**
  - If stack_empty, go to FLAT_RD with i=1 (see Configuration).
  - Otherwise, in the same cycle:
    - stack_pop=1;
    - tbl_raddr = stack_top min half;
    - tbl_we=1;
    - tbl_waddr = stack_top max half;
    - tbl_wdata = tbl_rdata.
  - This retires one merge pair per cycle.
- **FLAT_RD**
  - If i ≥ num_labels, go to DONE.
  - Otherwise set tbl_raddr=i, register r=tbl_rdata and go to FLAT_WR.
- **FLAT_WR**
  - tbl_raddr=r, tbl_we=1, tbl_waddr=i, tbl_wdata=tbl_rdata.
  - i increments; return to FLAT_RD.
  - Labels are processed in ascending order and the table invariant is table[k] ≤ k, so a single pass yields roots.
- **DONE**
  - done=1 for one cycle, then IDLE.

Boundary rules:
- start outside IDLE is ignored.
- num_labels is sampled live in FLAT_RD. It is stable after SCAN.
- The i counter is `WORD_SIZE wide and never exceeds num_labels.
- Reset asserted in any state returns immediately to IDLE. All registered outputs go to 0, and a partial frame is discarded.

## Timing
- Reset values:
  - pixel_ready, label_en, clr, stack_pop, tbl_we, busy and done are all 0.
  - x=0, y=0, tbl_raddr=0, tbl_waddr=0, tbl_wdata=0.
- State, x, y, i and r are registered.
- pixel_ready, label_en, stack_pop, tbl_* and done are decoded combinationally from the current state and inputs.
- start sampled at edge N: clr is high during cycle N+1, and the first pixel can be accepted in cycle N+2.
- Scan takes FRAME_W*FRAME_H accepted-pixel cycles plus any stall cycles.
- Drain takes P cycles for P stacked pairs, plus 1 cycle to observe empty.
- Flatten takes 2*(num_labels-1) + 1 cycles.
- Drain and flatten never stall.
- done is high for exactly one cycle; busy falls in the cycle after it.

## Configuration
- CCL_FLATTEN_EN defined: FLAT_RD/FLAT_WR are compiled in, and DRAIN-empty goes to FLAT_RD.
- CCL_FLATTEN_EN undefined: no flatten logic, DRAIN-empty goes directly to DONE, and the table is left with chained entries.

## Test plan
- **Reset:** FRAME_W=4, FRAME_H=2; assert reset_n=0 mid-SCAN at x=2,y=1 → all outputs 0 asynchronously; state IDLE; next start restarts with x=0,y=0.
- **Scan with stalls:** pixel_valid held high except 3 low cycles → exactly 8 label_en pulses; x,y sequence (0,0)…(3,1); 3 hold cycles; transition to DRAIN after (3,1).
- **Drain:** stack holds {5,2},{4,1}, table[2]=2, table[1]=1 → writes table[5]=2 then table[4]=1 in consecutive cycles; 2 stack_pop pulses.
- **Flatten (CCL_FLATTEN_EN):** num_labels=5, table={1:1, 2:1, 3:2, 4:3} → result {1,1,1,1}; done 8+1 cycles after drain exits.
- **No labels:** num_labels=1, stack empty → DRAIN 1 cycle, FLAT_RD 1 cycle, then done; tbl_we never asserted.
- **Protocol:** start pulsed during SCAN is ignored; without CCL_FLATTEN_EN, done follows drain-empty by one cycle.
